// File: rtl/bram_rd_pkg.sv
// Shared types and defaults for the BRAM1 result reader.
// Holds the state encoding and the read-credit helper.
package bram_rd_pkg;

    localparam int AWIDTH_DEF    = 8;
    localparam int DWIDTH_DEF    = 64;
    localparam int CNT_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when the rows already held or in flight, minus the beat leaving now,
    // still leave a free buffer slot for one more read.
    function automatic logic has_credit(input logic [1:0] buf_cnt,
                                        input logic       inflight,
                                        input logic       pop);
        return ({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/bram_result_reader_if.sv
// Valid/ready result stream carrying one BRAM row per beat.
interface bram_result_reader_if
    import bram_rd_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    logic              valid;
    logic [DWIDTH-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/result_fifo2.sv
// Two-entry FIFO that absorbs the BRAM read latency against stream backpressure.
module result_fifo2
    import bram_rd_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [1:0]        count
);
    logic [DWIDTH-1:0] mem_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (count_r == 2'd0);
    assign full      = (count_r == 2'd2);
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_r[0] <= {DWIDTH{1'b0}};
            mem_r[1] <= {DWIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/bram_result_reader.sv
// Walks a block of BRAM1 rows and streams them out, throttling reads so the
// two-entry buffer can never overflow under backpressure.
module bram_result_reader
    import bram_rd_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [AWIDTH-1:0]    base_addr_i,
    input  logic [CNT_WIDTH-1:0] rd_count_i,
    output logic                 idle_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AWIDTH-1:0]    addr_o,
    output logic                 ce_o,
    output logic                 we_o,
    output logic [DWIDTH-1:0]    d_o,
    input  logic [DWIDTH-1:0]    q_i,
    bram_result_reader_if.master m
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_r;
    state_t               state_s;
    logic [AWIDTH-1:0]    base_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] issued_r;
    logic [CNT_WIDTH-1:0] sent_r;
    logic                 inflight_r;
    logic                 start_ok_s;
    logic                 pop_s;
    logic                 issue_s;
    logic                 last_issue_s;
    logic                 last_beat_s;
    logic                 buf_empty_s;
    logic                 buf_full_s;
    logic [1:0]           buf_cnt_s;
    logic [DWIDTH-1:0]    buf_head_s;

    assign start_ok_s   = (state_r == IDLE) & start_i;
    assign pop_s        = ~buf_empty_s & m.ready;
    assign issue_s      = (state_r == RUN) & has_credit(buf_cnt_s, inflight_r, pop_s);
    assign last_issue_s = issue_s & (issued_r == count_r - CNT_ONE);
    assign last_beat_s  = ~buf_empty_s & (sent_r == count_r - CNT_ONE);

    assign idle_o  = (state_r == IDLE);
    assign busy_o  = (state_r == RUN) | (state_r == DRAIN);
    assign done_o  = (state_r == DONE);
    assign addr_o  = AWIDTH'(base_r + issued_r);
    assign ce_o    = issue_s;
    assign we_o    = 1'b0;
    assign d_o     = {DWIDTH{1'b0}};
    assign m.valid = ~buf_empty_s;
    assign m.data  = buf_head_s;
    assign m.last  = last_beat_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = (rd_count_i != {CNT_WIDTH{1'b0}}) ? RUN : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_issue_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (pop_s & last_beat_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, issue/beat counters and the one-cycle read-latency flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r     <= {AWIDTH{1'b0}};
            count_r    <= {CNT_WIDTH{1'b0}};
            issued_r   <= {CNT_WIDTH{1'b0}};
            sent_r     <= {CNT_WIDTH{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (start_ok_s) begin
                base_r   <= base_addr_i;
                count_r  <= rd_count_i;
                issued_r <= {CNT_WIDTH{1'b0}};
                sent_r   <= {CNT_WIDTH{1'b0}};
            end else begin
                if (issue_s) begin
                    issued_r <= issued_r + CNT_ONE;
                end
                if (pop_s) begin
                    sent_r <= sent_r + CNT_ONE;
                end
            end
        end
    end

    result_fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_r),
        .push_data (q_i),
        .pop       (pop_s),
        .head      (buf_head_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s),
        .count     (buf_cnt_s)
    );

    logic unused_s;
    assign unused_s = buf_full_s;
endmodule

// File: tb/tb_bram_result_reader.sv
// Scoreboard bench: expected addresses/rows are queued at start and matched
// against BRAM reads and accepted stream beats.
module tb_bram_result_reader;
    import bram_rd_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic [8:0]  rd_count = 9'd0;
    logic        idle, busy, done;
    logic [7:0]  addr;
    logic        ce, we;
    logic [63:0] d;
    logic [63:0] q = 64'd0;

    bram_result_reader_if #(.DWIDTH(64)) s_if ();

    bram_result_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .rd_count_i  (rd_count),
        .idle_o      (idle),
        .busy_o      (busy),
        .done_o      (done),
        .addr_o      (addr),
        .ce_o        (ce),
        .we_o        (we),
        .d_o         (d),
        .q_i         (q),
        .m           (s_if.master)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    logic [7:0]  exp_addr [$];
    logic [63:0] exp_data [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          beats_seen = 0;
    int          ce_seen = 0;
    int          outstanding = 0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM1 model: one-cycle read latency.
    always @(posedge clk) begin
        if (ce) q <= mem[addr];
    end

    // Downstream ready, changed just after each active edge.
    initial begin
        s_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: reads, beats, hold-while-stalled and outstanding-read bound.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (ce) begin
                ce_seen++;
                if (exp_addr.size() == 0) check("ce_extra", 64'd1, 64'd0);
                else check("addr", {56'd0, addr}, {56'd0, exp_addr.pop_front()});
            end
            if (prev_stall) begin
                check("hold_valid", {63'd0, s_if.valid}, 64'd1);
                check("hold_data", s_if.data, prev_data);
            end
            if (s_if.valid && s_if.ready) begin
                beats_seen++;
                if (exp_data.size() == 0) check("beat_extra", 64'd1, 64'd0);
                else begin
                    check("data", s_if.data, exp_data.pop_front());
                    check("last", {63'd0, s_if.last}, {63'd0, exp_data.size() == 0});
                end
            end
            outstanding = outstanding + int'(ce) - int'(s_if.valid && s_if.ready);
            if (ce) check("outstanding_le2", {63'd0, outstanding <= 2}, 64'd1);
            prev_stall = s_if.valid && !s_if.ready;
            prev_data  = s_if.data;
        end
    end

    task automatic check_reset_vals();
        check("rst_idle", {63'd0, idle}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ce", {63'd0, ce}, 64'd0);
        check("rst_addr", {56'd0, addr}, 64'd0);
        check("rst_valid", {63'd0, s_if.valid}, 64'd0);
        check("rst_last", {63'd0, s_if.last}, 64'd0);
        check("rst_data", s_if.data, 64'd0);
        check("rst_we_d", {63'd0, we | (|d)}, 64'd0);
    endtask

    task automatic queue_rows(input logic [7:0] b, input int c);
        for (int i = 0; i < c; i++) begin
            logic [7:0] a;
            a = b + 8'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
    endtask

    task automatic pulse_start(input logic [7:0] b, input int c);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        rd_count = 9'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 8'hAA;
        rd_count = 9'd5;
    endtask

    task automatic run_xfer(input logic [7:0] b, input int c, input bit rnd,
                            input bit lat, input bit inject);
        int cyc;
        bit got;
        rand_ready = rnd;
        beats_seen = 0;
        ce_seen = 0;
        queue_rows(b, c);
        pulse_start(b, c);
        cyc = 0;
        got = 1'b0;
        while (cyc < c * 8 + 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_c1", {63'd0, busy}, {63'd0, c != 0});
            if (done) got = 1'b1;
            if (inject && cyc == 4) begin
                start = 1'b1;
                base_addr = 8'h55;
                rd_count = 9'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", {63'd0, got}, 64'd1);
        if (lat) check("done_latency", 64'(cyc), (c == 0) ? 64'd1 : 64'(c + 3));
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("idle_after", {63'd0, idle}, 64'd1);
        check("beats", 64'(beats_seen), 64'(c));
        check("ce_count", 64'(ce_seen), 64'(c));
        check("rows_left", 64'(exp_data.size()), 64'd0);
        rand_ready = 1'b0;
    endtask

    initial begin
        int waitc;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        #2;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_xfer(8'h10, 4, 1'b0, 1'b1, 1'b0);
        run_xfer(8'h20, 0, 1'b0, 1'b1, 1'b0);
        run_xfer(8'hFE, 4, 1'b0, 1'b1, 1'b0);
        run_xfer(8'h80, 8, 1'b1, 1'b0, 1'b1);
        run_xfer(8'h00, 256, 1'b0, 1'b1, 1'b0);

        beats_seen = 0;
        queue_rows(8'h30, 8);
        pulse_start(8'h30, 8);
        waitc = 0;
        while (beats_seen < 3 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        check("pre_reset_beats", {63'd0, beats_seen >= 3}, 64'd1);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_xfer(8'h40, 2, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_result_reader.md
# bram_result_reader

Drains accumulated results out of BRAM1 after the accumulate pass has finished, walking `rd_count_i` consecutive rows from `base_addr_i` and presenting each 64-bit row on a valid/ready stream. It is the consumer end of the BRAM1 write interface: it drives the same addr/ce/we/d port as a pure reader and absorbs the BRAM's 1-cycle read latency and downstream backpressure with a 2-entry buffer. Control and state outputs mirror the accessor's IDLE/RUN/DONE convention so the register block can sequence both.

## Interface
- AWIDTH, 8, BRAM address width
- DWIDTH, 64, BRAM row width (4 × 16-bit results)
- CNT_WIDTH, 9, row-count width; must be AWIDTH+1 so a full 2^AWIDTH sweep is expressible

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  AWIDTH  first row address; captured on accepted start
- rd_count_i  in  CNT_WIDTH  rows to read; captured on accepted start
- idle_o / busy_o / done_o  out  1 each  state outputs
- addr_o  out  AWIDTH  BRAM1 address
- ce_o  out  1  BRAM1 chip enable, high only on a read issue
- we_o  out  1  tied 0
- d_o  out  DWIDTH  tied 0
- q_i  in  DWIDTH  BRAM1 read data, valid the cycle after ce_o
- m_valid_o  out  1  stream beat valid
- m_data_o  out  DWIDTH  stream data
- m_last_o  out  1  high with the final beat
- m_ready_i  in  1  downstream ready

## Operation
- FSM: IDLE → RUN on start_i with rd_count_i≠0; IDLE → DONE on start_i with rd_count_i==0 (no reads, no beats); RUN → DRAIN when the last read issues; DRAIN → DONE when the beat with m_last_o is accepted; DONE → IDLE unconditionally.
- idle_o = (state==IDLE); busy_o = RUN or DRAIN; done_o = (state==DONE), exactly one cycle.
- start_i outside IDLE is ignored; captured operands are not disturbed.
- Issue counter `issued` (CNT_WIDTH) from 0; addr_o = base + issued, truncated to AWIDTH (wraps modulo 2^AWIDTH).
- In-flight flag set on issue, cleared the following cycle when q_i is written into the buffer.
- Credit rule: issue in RUN iff (buf_cnt + inflight − pop) < 2, where pop = m_valid_o & m_ready_i. Guarantees no buffer overflow and no dropped q_i.
- Buffer: 2-entry FIFO; head drives m_data_o; m_valid_o = buf non-empty. Data stable while m_valid_o & !m_ready_i.
- Beat counter `sent` increments on pop; m_last_o = m_valid_o & (sent == count−1).
- Simultaneous push and pop on a full or 1-entry buffer are legal; occupancy unchanged.

## Timing
- Reset values: state IDLE, idle_o=1, busy_o=0, done_o=0, ce_o=0, addr_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, counters and buffer cleared.
- Start accepted at edge E0; cycle 1: ce_o=1, addr_o=base; cycle 2: q_i valid, pushed at E2; cycle 3: first m_valid_o.
- With m_ready_i held high: one beat per cycle sustained; N rows take N+3 cycles from start to done_o.
- m_ready_i low: at most 2 reads outstanding in buffer+flight; ce_o stalls until credit frees.
- reset_n asserted mid-transfer: immediate return to reset values; in-flight q_i is discarded.

## Structure
- Package bram_rd_pkg: state enum (IDLE, RUN, DRAIN, DONE), default AWIDTH/DWIDTH/CNT_WIDTH constants.
- One sub-module: result_fifo2 (2-entry, DWIDTH-wide, push/pop/empty/full/count). Top holds FSM, counters, credit logic.

## Test plan
- count=4, base=0x10, ready=1 → ce_o on addrs 0x10..0x13 in consecutive cycles, 4 beats back-to-back, m_last_o on 4th, done_o 7 cycles after start.
- count=0 → done_o one cycle after start, no ce_o, no m_valid_o.
- base=0xFE, count=4 → addresses 0xFE, 0xFF, 0x00, 0x01; data order matches BRAM model.
- count=8, m_ready_i random 50% → all 8 rows delivered in order, data held stable while stalled, never >2 reads outstanding.
- count=256, base=0 → full sweep, 256 beats, m_last_o only on the final one.
- reset_n pulsed after 3 beats, then fresh start count=2 → outputs at reset values, second transfer delivers exactly 2 correct beats.
